// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the EX/M register, the memory/write-back stage,
// and the register file / PC mux it feeds.
interface mem_wb_stage_if;
  logic        MemWr_i;
  logic        Branch_i;
  logic        Jump_i;
  logic        MemtoReg_i;
  logic        Regwr_i;
  logic        Zero_i;
  logic [31:0] busB_i;
  logic [31:0] ALUout_i;
  logic [31:0] Rd_i;
  logic [31:0] Target_i;

  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        Regwr;
  logic        MemtoReg;
  logic [4:0]  Rw;
  logic [31:0] ALUout;
  logic [31:0] Dout;
  logic [31:0] busW;
  logic        AddrErr;

  // The stage itself consumes EX/M outputs and produces write-back/PC signals
  modport slave (
    input  MemWr_i, Branch_i, Jump_i, MemtoReg_i, Regwr_i, Zero_i,
    input  busB_i, ALUout_i, Rd_i, Target_i,
    output PCSrc, PCTarget, Regwr, MemtoReg, Rw, ALUout, Dout, busW, AddrErr
  );

  modport master (
    output MemWr_i, Branch_i, Jump_i, MemtoReg_i, Regwr_i, Zero_i,
    output busB_i, ALUout_i, Rd_i, Target_i,
    input  PCSrc, PCTarget, Regwr, MemtoReg, Rw, ALUout, Dout, busW, AddrErr
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage: word-addressed data memory, next-PC select, and the
// MEM/WB pipeline register. All state updates on the falling edge of CLK.
module mem_wb_stage #(
  parameter int ADDR_W = 8
) (
  input  logic           CLK,
  input  logic           Resetn,
  mem_wb_stage_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] waddr;
  logic              aligned;
  logic              store_ok;
  logic              unused_rd_hi;

  // Byte address bits above the memory range are dropped, so addresses wrap
  assign waddr        = bus.ALUout_i[ADDR_W+1:2];
  assign aligned      = (bus.ALUout_i[1:0] == 2'b00);
  assign store_ok     = Resetn && bus.MemWr_i && aligned;
  assign unused_rd_hi = ^bus.Rd_i[31:5];

  assign bus.PCSrc    = bus.Jump_i | (bus.Branch_i & bus.Zero_i);
  assign bus.PCTarget = bus.Target_i;
  assign bus.busW     = bus.MemtoReg ? bus.Dout : bus.ALUout;

  always_ff @(negedge CLK) begin
    if (store_ok)
      mem[waddr] <= bus.busB_i;
  end

  // Dout samples the pre-write word, giving old-data read-during-write
  always_ff @(negedge CLK) begin
    if (!Resetn) begin
      bus.Regwr    <= 1'b0;
      bus.MemtoReg <= 1'b0;
      bus.Rw       <= 5'd0;
      bus.ALUout   <= 32'd0;
      bus.Dout     <= 32'd0;
      bus.AddrErr  <= 1'b0;
    end else begin
      bus.Regwr    <= bus.Regwr_i;
      bus.MemtoReg <= bus.MemtoReg_i;
      bus.Rw       <= bus.Rd_i[4:0];
      bus.ALUout   <= bus.ALUout_i;
      bus.Dout     <= mem[waddr];
      if (bus.MemWr_i && !aligned)
        bus.AddrErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a reference memory model pushes the
// expected MEM/WB contents per instruction; each scenario pops and compares.
module tb_mem_wb_stage;

  typedef struct {
    logic        regwr;
    logic        memtoreg;
    logic [4:0]  rw;
    logic [31:0] aluout;
    logic [31:0] dout;
    bit          dout_known;
    logic        addrerr;
  } exp_t;

  logic CLK    = 1'b1;
  logic Resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t        sb [$];
  logic [31:0] model_mem [256];
  bit          model_valid [256];
  bit          model_err = 1'b0;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.ADDR_W(8)) dut (
    .CLK    (CLK),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic cycle();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.MemWr_i    = 1'b0;
    bus.Branch_i   = 1'b0;
    bus.Jump_i     = 1'b0;
    bus.MemtoReg_i = 1'b0;
    bus.Regwr_i    = 1'b0;
    bus.Zero_i     = 1'b0;
    bus.busB_i     = 32'd0;
    bus.ALUout_i   = 32'd0;
    bus.Rd_i       = 32'd0;
    bus.Target_i   = 32'd0;
  endtask

  // Drive one instruction with Resetn=1 and push what MEM/WB should hold after the edge
  task automatic drive(input logic memwr, input logic regwr, input logic memtoreg,
                       input logic [31:0] rd, input logic [31:0] alu, input logic [31:0] busb);
    exp_t e;
    int   idx;
    bus.MemWr_i    = memwr;
    bus.Regwr_i    = regwr;
    bus.MemtoReg_i = memtoreg;
    bus.Rd_i       = rd;
    bus.ALUout_i   = alu;
    bus.busB_i     = busb;
    idx = int'(alu[9:2]);
    e.regwr      = regwr;
    e.memtoreg   = memtoreg;
    e.rw         = rd[4:0];
    e.aluout     = alu;
    e.dout       = model_mem[idx];
    e.dout_known = model_valid[idx];
    if (memwr) begin
      if (alu[1:0] == 2'b00) begin
        model_mem[idx]   = busb;
        model_valid[idx] = 1'b1;
      end else begin
        model_err = 1'b1;
      end
    end
    e.addrerr = model_err;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h10, 32'h1111_1111);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.ALUout !== e.aluout) begin n_fail++; $display("[TB] FAIL rst_preload_alu: got %h expected %h", bus.ALUout, e.aluout); end

    Resetn = 1'b0;
    bus.MemWr_i = 1'b1; bus.ALUout_i = 32'h10; bus.busB_i = 32'hDEAD_BEEF;
    bus.Regwr_i = 1'b1; bus.MemtoReg_i = 1'b1; bus.Rd_i = 32'd5;
    cycle();
    cycle();
    n_checks++; if (bus.Regwr !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_regwr: got %b expected 0", bus.Regwr); end
    n_checks++; if (bus.MemtoReg !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_memtoreg: got %b expected 0", bus.MemtoReg); end
    n_checks++; if (bus.Rw !== 5'd0) begin n_fail++; $display("[TB] FAIL rst_rw: got %0d expected 0", bus.Rw); end
    n_checks++; if (bus.ALUout !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_aluout: got %h expected 0", bus.ALUout); end
    n_checks++; if (bus.Dout !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_dout: got %h expected 0", bus.Dout); end
    n_checks++; if (bus.busW !== 32'd0) begin n_fail++; $display("[TB] FAIL rst_busw: got %h expected 0", bus.busW); end
    n_checks++; if (bus.AddrErr !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_addrerr: got %b expected 0", bus.AddrErr); end
    n_checks++; if (bus.PCSrc !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pcsrc: got %b expected 0", bus.PCSrc); end

    Resetn = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'd3, 32'h10, 32'd0);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.busW !== 32'h1111_1111) begin n_fail++; $display("[TB] FAIL rst_retained: got %h expected %h", bus.busW, 32'h1111_1111); end
    n_checks++; if (bus.Dout !== e.dout) begin n_fail++; $display("[TB] FAIL rst_retained_dout: got %h expected %h", bus.Dout, e.dout); end
  endtask

  task automatic test_store_load();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h20, 32'h1234_5678);
    cycle();
    e = sb.pop_front();
    drive(1'b0, 1'b1, 1'b1, 32'd7, 32'h20, 32'd0);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.Dout !== e.dout) begin n_fail++; $display("[TB] FAIL sl_dout: got %h expected %h", bus.Dout, e.dout); end
    n_checks++; if (bus.busW !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL sl_busw: got %h expected %h", bus.busW, 32'h1234_5678); end
    n_checks++; if (bus.Rw !== e.rw) begin n_fail++; $display("[TB] FAIL sl_rw: got %0d expected %0d", bus.Rw, e.rw); end
    n_checks++; if (bus.Regwr !== e.regwr) begin n_fail++; $display("[TB] FAIL sl_regwr: got %b expected %b", bus.Regwr, e.regwr); end
    n_checks++; if (bus.MemtoReg !== e.memtoreg) begin n_fail++; $display("[TB] FAIL sl_memtoreg: got %b expected %b", bus.MemtoReg, e.memtoreg); end
  endtask

  task automatic test_wrap();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h400, 32'hA5A5_A5A5);
    cycle();
    e = sb.pop_front();
    drive(1'b0, 1'b1, 1'b1, 32'd9, 32'h000, 32'd0);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.busW !== 32'hA5A5_A5A5) begin n_fail++; $display("[TB] FAIL wrap_busw: got %h expected %h", bus.busW, 32'hA5A5_A5A5); end
    n_checks++; if (bus.Dout !== e.dout) begin n_fail++; $display("[TB] FAIL wrap_dout: got %h expected %h", bus.Dout, e.dout); end
  endtask

  task automatic test_misaligned();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h22, 32'hFFFF_FFFF);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.AddrErr !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_flag: got %b expected 1", bus.AddrErr); end
    // Low address bits are ignored on reads, so 0x23 reads word 0x20
    drive(1'b0, 1'b1, 1'b1, 32'd4, 32'h23, 32'd0);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.Dout !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL mis_unchanged: got %h expected %h", bus.Dout, 32'h1234_5678); end
    n_checks++; if (bus.AddrErr !== e.addrerr) begin n_fail++; $display("[TB] FAIL mis_sticky1: got %b expected %b", bus.AddrErr, e.addrerr); end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h40, 32'h0000_0000);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.AddrErr !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_sticky2: got %b expected 1", bus.AddrErr); end
    Resetn = 1'b0;
    clear_inputs();
    cycle();
    n_checks++; if (bus.AddrErr !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_clear: got %b expected 0", bus.AddrErr); end
    model_err = 1'b0;
    Resetn = 1'b1;
  endtask

  task automatic test_branch_jump();
    bus.Target_i = 32'h0040_0080;
    bus.Branch_i = 1'b1; bus.Zero_i = 1'b0; bus.Jump_i = 1'b0;
    #1;
    n_checks++; if (bus.PCSrc !== 1'b0) begin n_fail++; $display("[TB] FAIL bj_not_taken: got %b expected 0", bus.PCSrc); end
    bus.Zero_i = 1'b1;
    #1;
    n_checks++; if (bus.PCSrc !== 1'b1) begin n_fail++; $display("[TB] FAIL bj_taken: got %b expected 1", bus.PCSrc); end
    n_checks++; if (bus.PCTarget !== 32'h0040_0080) begin n_fail++; $display("[TB] FAIL bj_target: got %h expected %h", bus.PCTarget, 32'h0040_0080); end
    bus.Branch_i = 1'b0; bus.Zero_i = 1'b0; bus.Jump_i = 1'b1; bus.Target_i = 32'h0000_1234;
    #1;
    n_checks++; if (bus.PCSrc !== 1'b1) begin n_fail++; $display("[TB] FAIL bj_jump: got %b expected 1", bus.PCSrc); end
    n_checks++; if (bus.PCTarget !== 32'h0000_1234) begin n_fail++; $display("[TB] FAIL bj_target2: got %h expected %h", bus.PCTarget, 32'h0000_1234); end
    bus.Branch_i = 1'b1;
    #1;
    n_checks++; if (bus.PCSrc !== 1'b1) begin n_fail++; $display("[TB] FAIL bj_both: got %b expected 1", bus.PCSrc); end
    bus.Jump_i = 1'b0; bus.Branch_i = 1'b0; bus.Zero_i = 1'b1;
    #1;
    n_checks++; if (bus.PCSrc !== 1'b0) begin n_fail++; $display("[TB] FAIL bj_zero_only: got %b expected 0", bus.PCSrc); end
    bus.Zero_i = 1'b0; bus.Target_i = 32'd0;
    cycle();
  endtask

  task automatic test_read_during_write();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h30, 32'h0000_0001);
    cycle();
    e = sb.pop_front();
    drive(1'b1, 1'b0, 1'b1, 32'd2, 32'h30, 32'h0000_0002);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.Dout !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL rdw_old: got %h expected %h", bus.Dout, 32'h0000_0001); end
    n_checks++; if (bus.Dout !== e.dout) begin n_fail++; $display("[TB] FAIL rdw_model: got %h expected %h", bus.Dout, e.dout); end
    drive(1'b0, 1'b0, 1'b1, 32'd2, 32'h30, 32'd0);
    cycle();
    e = sb.pop_front();
    n_checks++; if (bus.Dout !== 32'h0000_0002) begin n_fail++; $display("[TB] FAIL rdw_new: got %h expected %h", bus.Dout, 32'h0000_0002); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] alu;
    for (int i = 0; i < 30; i++) begin
      alu = 32'h80 + {$urandom_range(0, 7), 2'b00};
      if ($urandom_range(0, 9) == 0) alu[1:0] = 2'b10;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom(), alu, $urandom());
      cycle();
      e = sb.pop_front();
      n_checks++; if (bus.Regwr !== e.regwr) begin n_fail++; $display("[TB] FAIL b2b_regwr[%0d]: got %b expected %b", i, bus.Regwr, e.regwr); end
      n_checks++; if (bus.MemtoReg !== e.memtoreg) begin n_fail++; $display("[TB] FAIL b2b_memtoreg[%0d]: got %b expected %b", i, bus.MemtoReg, e.memtoreg); end
      n_checks++; if (bus.Rw !== e.rw) begin n_fail++; $display("[TB] FAIL b2b_rw[%0d]: got %0d expected %0d", i, bus.Rw, e.rw); end
      n_checks++; if (bus.ALUout !== e.aluout) begin n_fail++; $display("[TB] FAIL b2b_aluout[%0d]: got %h expected %h", i, bus.ALUout, e.aluout); end
      n_checks++; if (bus.AddrErr !== e.addrerr) begin n_fail++; $display("[TB] FAIL b2b_addrerr[%0d]: got %b expected %b", i, bus.AddrErr, e.addrerr); end
      if (e.dout_known) begin
        n_checks++; if (bus.Dout !== e.dout) begin n_fail++; $display("[TB] FAIL b2b_dout[%0d]: got %h expected %h", i, bus.Dout, e.dout); end
      end
      if (!e.memtoreg) begin
        n_checks++; if (bus.busW !== e.aluout) begin n_fail++; $display("[TB] FAIL b2b_busw_alu[%0d]: got %h expected %h", i, bus.busW, e.aluout); end
      end else if (e.dout_known) begin
        n_checks++; if (bus.busW !== e.dout) begin n_fail++; $display("[TB] FAIL b2b_busw_mem[%0d]: got %h expected %h", i, bus.busW, e.dout); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_mem[i]   = 32'd0;
      model_valid[i] = 1'b0;
    end
    clear_inputs();
    Resetn = 1'b0;
    cycle();
    cycle();
    Resetn = 1'b1;
    test_reset();
    test_store_load();
    test_wrap();
    test_misaligned();
    test_branch_jump();
    test_read_during_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
